// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-back entry bundle.
// Imported by the FIFO and the arbiter.
package pkg_parameters;

  localparam int XLEN       = 32;
  localparam int NUM_REG    = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REG);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO of write-back entries.
// Separate count register, so full/empty need no pointer wrap tricks.
module wb_fifo
  import pkg_parameters::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  wb_entry_t       i_din,
  input  logic            i_pop,
  output wb_entry_t       o_dout,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) f_inc = '0;
    else                     f_inc = p + 1'b1;
  endfunction

  // Storage array; contents need no reset, the count guards reads.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= f_inc(r_wptr);
      if (i_pop)  r_rptr <= f_inc(r_rptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU first, then buffered long-latency results,
// then LSU cut-through. Tracks outstanding long-latency destinations.
module wb_arbiter
  import pkg_parameters::*;
#(
  parameter int XLEN       = pkg_parameters::XLEN,
  parameter int NUM_OF_REG = pkg_parameters::NUM_REG,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_hold,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic [NUM_OF_REG-1:0] busy,
  output logic                  rd_web,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  wb_entry_t       w_head;
  wb_entry_t       w_lsu_ent;
  logic            w_xfer;
  logic            w_pop;
  logic            w_cut;
  logic            w_push;
  logic            w_sel_vld;
  logic            w_sel_lsu;
  wb_entry_t       w_sel;
  logic [NUM_OF_REG-1:0] w_busy_nxt;

  logic [NUM_OF_REG-1:0] r_busy;
  logic                  r_web;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_data;

  assign lsu_ready = (w_count < CW'(FIFO_DEPTH));
  assign alu_hold  = w_full;

  assign w_lsu_ent = '{addr: lsu_addr, data: lsu_data};
  assign w_xfer    = lsu_valid && lsu_ready;
  assign w_pop     = !alu_valid && !w_empty;
  assign w_cut     = !alu_valid && w_empty && w_xfer;
  assign w_push    = w_xfer && !w_cut;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_lsu_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Priority select of the write-port source.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_lsu = 1'b0;
    w_sel     = '0;
    unique case (1'b1)
      alu_valid: begin
        w_sel_vld = 1'b1;
        w_sel     = '{addr: alu_addr, data: alu_data};
      end
      w_pop: begin
        w_sel_vld = 1'b1;
        w_sel_lsu = 1'b1;
        w_sel     = w_head;
      end
      w_cut: begin
        w_sel_vld = 1'b1;
        w_sel_lsu = 1'b1;
        w_sel     = w_lsu_ent;
      end
      default: ;
    endcase
  end

  // Scoreboard update: clear on LSU write-back, then a new issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_sel_lsu)
      w_busy_nxt[w_sel.addr] = 1'b0;
    if (iss_valid && (iss_addr != '0))
      w_busy_nxt[iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Register the write port and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_web  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_web  <= w_sel_vld && (w_sel.addr != '0);
      if (w_sel_vld) begin
        r_addr <= w_sel.addr;
        r_data <= w_sel.data;
      end
    end
  end

  assign busy    = r_busy;
  assign rd_web  = r_web;
  assign rd_addr = r_addr;
  assign rd_data = r_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-by-cycle vector table
// plus a hand-written mid-operation reset sequence.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_hold;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [31:0] busy;
  logic        rd_web;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_hold  (alu_hold),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .rd_web    (rd_web),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Upstream must not present an ALU result while the FIFO is full.
  always @(posedge clk) begin
    if (!rst && alu_valid)
      assert (!alu_hold) else $error("alu_valid while alu_hold");
  end

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ia;
    logic        web;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] bsy;
    logic        rdy;
    logic        hold;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic web,
                         input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] bsy, input logic rdy,
                         input logic hold);
    chk({tag, ".rd_web"},    64'(rd_web),    64'(web));
    chk({tag, ".rd_addr"},   64'(rd_addr),   64'(addr));
    chk({tag, ".rd_data"},   64'(rd_data),   64'(data));
    chk({tag, ".busy"},      64'(busy),      64'(bsy));
    chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(rdy));
    chk({tag, ".alu_hold"},  64'(alu_hold),  64'(hold));
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  initial begin
    // av aa ad   lv la ld   iv ia   web addr data busy rdy hold
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                 1, 5, 32'hDEADBEEF, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 5, 32'hDEADBEEF, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 7,
                 0, 5, 32'hDEADBEEF, 32'h80, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 5, 32'hDEADBEEF, 32'h80, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 5, 32'hDEADBEEF, 32'h80, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 7, 32'h1234, 0, 0,
                 1, 7, 32'h1234, 0, 1, 0};
    vecs[6]  = '{1, 10, 32'h11, 0, 0, 0, 0, 0,
                 1, 10, 32'h11, 0, 1, 0};
    vecs[7]  = '{1, 11, 32'h22, 1, 3, 32'hA, 1, 3,
                 1, 11, 32'h22, 32'h8, 1, 0};
    vecs[8]  = '{1, 12, 32'h33, 1, 4, 32'hB, 1, 4,
                 1, 12, 32'h33, 32'h18, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 1, 3, 32'hA, 32'h10, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 1, 4, 32'hB, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 4, 32'hB, 0, 1, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 9,
                 0, 4, 32'hB, 32'h200, 1, 0};
    vecs[13] = '{0, 0, 0, 1, 9, 32'h99, 1, 9,
                 1, 9, 32'h99, 32'h200, 1, 0};
    vecs[14] = '{0, 0, 0, 1, 9, 32'h98, 0, 0,
                 1, 9, 32'h98, 0, 1, 0};
    vecs[15] = '{1, 0, 32'h55, 0, 0, 0, 0, 0,
                 0, 0, 32'h55, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 1, 0, 32'h66, 1, 0,
                 0, 0, 32'h66, 0, 1, 0};
    vecs[17] = '{1, 1, 32'h1, 1, 2, 32'h2, 0, 0,
                 1, 1, 32'h1, 0, 1, 0};
    vecs[18] = '{0, 0, 0, 1, 6, 32'h6, 0, 0,
                 1, 2, 32'h2, 0, 1, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 1, 6, 32'h6, 0, 1, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 6, 32'h6, 0, 1, 0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < NV; i++) begin
      alu_valid = vecs[i].av;
      alu_addr  = vecs[i].aa;
      alu_data  = vecs[i].ad;
      lsu_valid = vecs[i].lv;
      lsu_addr  = vecs[i].la;
      lsu_data  = vecs[i].ld;
      iss_valid = vecs[i].iv;
      iss_addr  = vecs[i].ia;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].web, vecs[i].addr,
              vecs[i].data, vecs[i].bsy, vecs[i].rdy, vecs[i].hold);
    end

    // Fill the FIFO, then reset while two entries are pending.
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h10;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h30;
    iss_valid = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h20;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h40;
    iss_valid = 1'b0; iss_addr = '0;
    @(negedge clk);
    chk_all("fill", 1, 2, 32'h20, 32'h8, 0, 1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("postrst%0d", i), 0, 0, 0, 0, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter feeding the register file's single `rd` write port. It merges single-cycle ALU results with results from a long-latency unit (LSU/MDU), buffering the latter in a small FIFO. It also keeps a scoreboard of destination registers that have outstanding long-latency writes, which issue logic uses to stall dependent instructions.

## Interface
Parameters:
- `XLEN`, default `pkg_parameters::XLEN` (32): data width.
- `NUM_OF_REG`, default `pkg_parameters::NUM_REG` (32): number of architectural registers.
- `FIFO_DEPTH`, default 2: long-latency buffer entries, ≥1.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `alu_valid`, in, 1: ALU result present this cycle; always accepted.
- `alu_addr`, in, 5: ALU destination register.
- `alu_data`, in, XLEN: ALU result.
- `alu_hold`, out, 1: FIFO full; upstream must deassert `alu_valid` while this is high.
- `lsu_valid`, in, 1: long-latency result offered.
- `lsu_ready`, out, 1: high when the FIFO count is below `FIFO_DEPTH`; a transfer happens when `lsu_valid && lsu_ready`.
- `lsu_addr`, in, 5: long-latency destination register.
- `lsu_data`, in, XLEN: long-latency result.
- `iss_valid`, in, 1: issue of a long-latency instruction.
- `iss_addr`, in, 5: destination of that instruction.
- `busy`, out, NUM_OF_REG: scoreboard, one bit per register; bit 0 is always 0.
- `rd_web`, out, 1: register-file write enable.
- `rd_addr`, out, 5: write address.
- `rd_data`, out, XLEN: write data.

## Operation
Selection is evaluated each cycle, in priority order:
1. If `alu_valid`, the ALU result is selected.
2. Otherwise, if the FIFO is non-empty, the FIFO head is popped and selected.
3. Otherwise, if an LSU transfer occurs, it cuts through the FIFO and is selected directly.
4. Otherwise nothing is selected.

Write-port register:
- If something is selected, `rd_web`, `rd_addr` and `rd_data` are registered from the selected source.
- If nothing is selected, `rd_web` becomes 0. `rd_addr` and `rd_data` hold their previous values.
- A selected entry with address 0 gives `rd_web=0`, so no write is issued for x0.

FIFO push rules:
- An LSU transfer that is not cut through is pushed into the FIFO.
- Pushes and pops may happen in the same cycle. Order is strictly FIFO.
- A push is never accepted when the FIFO is full, because `lsu_ready` is 0.

Scoreboard:
- `busy[a]` is set when `iss_valid` is high and `iss_addr == a != 0`.
- `busy[a]` is cleared on the edge that registers an LSU-sourced write to `a`, whether popped from the FIFO or cut through.
- If a set and a clear for the same register fall in the same cycle, set wins.
- ALU writes never touch `busy`.

Status outputs:
- `alu_hold` equals (count == `FIFO_DEPTH`).
- If `alu_valid` arrives while `alu_hold` is high, ALU priority still applies. This is an upstream protocol violation, and the bench flags it with an assertion.

## Timing
- Reset values: `rd_web=0`, `rd_addr=0`, `rd_data=0`, `busy=0`, FIFO count 0, so `lsu_ready=1` and `alu_hold=0`.
- Reset asserted mid-operation discards all FIFO entries and outstanding scoreboard bits immediately. Any write in flight is dropped.
- ALU latency is 1: `alu_valid` at cycle N gives `rd_web=1` in cycle N+1.
- LSU cut-through latency is 1. LSU latency from the FIFO is 1 plus the number of cycles the entry waits behind the ALU or older entries.
- `lsu_ready` and `alu_hold` are combinational decodes of the registered count, with no path from `lsu_valid`.
- `busy[a]` rises in the cycle after `iss_valid`. It falls in the same cycle that `rd_web=1` appears for the LSU write.
- There is no wrap-around ambiguity: the read and write pointers are `$clog2(FIFO_DEPTH)`-bit, with a separate count register of width `$clog2(FIFO_DEPTH+1)`.

## Structure
- `pkg_parameters` gains `REG_ADDR_W = $clog2(NUM_REG)`.
- `pkg_parameters` gains the typedef `wb_entry_t` (packed struct: `addr`[REG_ADDR_W], `data`[XLEN]).
- The 5-bit address ports above are declared with `REG_ADDR_W`.
- One sub-module, `wb_fifo`: a synchronous FIFO of `wb_entry_t` with push, pop, full, empty and count outputs, and the same `clk`/`rst`.
- The scoreboard and selection logic stay inline in `wb_arbiter`.
- `rd_web`, `rd_addr` and `rd_data` connect to the `rd_port` of the register-file interface.

## Test plan
- Reset release, idle: all outputs 0 and `lsu_ready=1`. Then `alu_valid`, `alu_addr=5`, `alu_data=0xDEADBEEF` at cycle N gives `rd_web=1`, `rd_addr=5`, `rd_data=0xDEADBEEF` at N+1 and `rd_web=0` at N+2.
- `iss_valid`, `iss_addr=7` at cycle 1 gives `busy[7]=1` from cycle 2. An LSU transfer of (7, 0x1234) at cycle 4 with no ALU gives `rd_web=1`, `rd_addr=7`, `rd_data=0x1234` and `busy[7]=0` at cycle 5.
- ALU valid for 3 consecutive cycles while the LSU offers (3, 0xA), then (4, 0xB):
  - Both are buffered, count reaches 2, `lsu_ready=0` and `alu_hold=1`.
  - After the ALU stops, writes x3=0xA and then x4=0xB follow on consecutive cycles.
- Same-cycle `iss_valid` for addr 9 and LSU-sourced selection of addr 9: `busy[9]` stays 1.
- An ALU write and an LSU write to addr 0 both give `rd_web=0`. `iss_addr=0` leaves `busy[0]=0`.
- `rst` asserted mid-cycle with 2 FIFO entries: count 0, `busy=0` and `rd_web=0` immediately. After release, no stale write appears.
